// File: rtl/exec_pkg.sv
// exec_pkg: opcode, branch-type and multiplier constants shared by the
// execute stage and its iterative multiplier.
package exec_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_ANDN = 4'd3;
    localparam logic [3:0] OP_ROL  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_ROR  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SEQ  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLE  = 4'd10;
    localparam logic [3:0] OP_SCO  = 4'd11;
    localparam logic [3:0] OP_BTR  = 4'd12;
    localparam logic [3:0] OP_LBI  = 4'd13;
    localparam logic [3:0] OP_SLBI = 4'd14;
    localparam logic [3:0] OP_MUL  = 4'd15;

    localparam logic [2:0] BR_NONE   = 3'd0;
    localparam logic [2:0] BR_BEQZ   = 3'd1;
    localparam logic [2:0] BR_BNEZ   = 3'd2;
    localparam logic [2:0] BR_BLTZ   = 3'd3;
    localparam logic [2:0] BR_BGEZ   = 3'd4;
    localparam logic [2:0] BR_JUMP   = 3'd5;
    localparam logic [2:0] BR_JUMPPC = 3'd6;

    localparam int MULT_ITERS = 16;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_BUSY = 2'd1,
        M_DONE = 2'd2
    } mult_state_t;

    function automatic logic [15:0] bit_rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/execute_stage_cells.sv
// execute_stage_cells: enable-gated flop cells used to build the EX/MEM
// pipeline register; asynchronous active-high reset clears to zero.
module reg16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 16'h0000;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

module reg3bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] d,
    output logic [2:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 3'b000;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

module dff_en (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/execute_stage_seq_mult.sv
// seq_mult: 16-iteration shift-add multiplier keeping the low 16 product
// bits; the result is held in DONE until the consumer acknowledges it.
module seq_mult
    import exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    input  logic        ack,
    output logic [15:0] product
);
    localparam int CW = $clog2(MULT_ITERS);

    mult_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_acc;
    logic [15:0]   r_mcand;
    logic [15:0]   r_mplier;
    logic          r_busy;
    logic          r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= M_IDLE;
            r_cnt    <= '0;
            r_acc    <= 16'h0000;
            r_mcand  <= 16'h0000;
            r_mplier <= 16'h0000;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                M_IDLE: begin
                    if (start) begin
                        r_state  <= M_BUSY;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_acc    <= 16'h0000;
                        r_mcand  <= a;
                        r_mplier <= b;
                    end
                end
                M_BUSY: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CW'(MULT_ITERS - 1)) begin
                        r_state <= M_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                M_DONE: begin
                    if (ack) begin
                        r_state <= M_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= M_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_acc;

endmodule

// File: rtl/execute_stage.sv
// execute_stage: ALU, branch/jump resolution and the EX/MEM register.
// Define MULT_EN to implement op 15 with the iterative multiplier.
module execute_stage
    import exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        Valid_IDEX,
    input  logic [15:0] Rd1_IDEX,
    input  logic [15:0] Rd2_IDEX,
    input  logic [15:0] Imm_IDEX,
    input  logic [15:0] PCinc_IDEX,
    input  logic [3:0]  ALUOp_IDEX,
    input  logic        ALUSrc_IDEX,
    input  logic [2:0]  BrType_IDEX,
    input  logic        MemRead_IDEX,
    input  logic        MemWrite_IDEX,
    input  logic        MemtoReg_IDEX,
    input  logic        RegWrite_IDEX,
    input  logic        Dump_IDEX,
    input  logic        halt_IDEX,
    input  logic [2:0]  WrR_IDEX,
    output logic        takeBranch,
    output logic [15:0] branchTarget,
    output logic        exStall,
    output logic [15:0] ALUO_EXMEM,
    output logic [15:0] Rd2_EXMEM,
    output logic        takeBranch_EXMEM,
    output logic        MemRead_EXMEM,
    output logic        MemWrite_EXMEM,
    output logic        MemtoReg_EXMEM,
    output logic        RegWrite_EXMEM,
    output logic        Dump_EXMEM,
    output logic        halt_EXMEM,
    output logic [2:0]  WrR_EXMEM
);
    logic [15:0] w_b;
    logic [3:0]  w_sh;
    logic [4:0]  w_sh_inv;
    logic [16:0] w_sum;
    logic [15:0] w_alu;
    logic [15:0] w_mul_res;
    logic        w_cond;
    logic [15:0] w_target;
    logic        w_is_jump;
    logic        w_live;
    logic [15:0] w_aluo_d;
    logic [15:0] w_rd2_d;
    logic [2:0]  w_wrr_d;
    logic [6:0]  w_ctl_d;
    logic [6:0]  w_ctl_q;

    assign w_b      = ALUSrc_IDEX ? Imm_IDEX : Rd2_IDEX;
    assign w_sh     = w_b[3:0];
    assign w_sh_inv = 5'd16 - {1'b0, w_sh};
    assign w_sum    = {1'b0, Rd1_IDEX} + {1'b0, w_b};

`ifdef MULT_EN
    logic w_is_mul;
    logic w_mul_busy;
    logic w_mul_done;

    assign w_is_mul = Valid_IDEX & (ALUOp_IDEX == OP_MUL);

    seq_mult u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (w_is_mul),
        .a       (Rd1_IDEX),
        .b       (w_b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .ack     (freeze),
        .product (w_mul_res)
    );

    // DONE drops the stall so the held product can be latched into EX/MEM
    assign exStall = w_is_mul & (w_mul_busy | ~w_mul_done);
`else
    assign w_mul_res = 16'h0000;
    assign exStall   = 1'b0;
`endif

    always_comb begin
        w_alu = 16'h0000;
        unique case (ALUOp_IDEX)
            OP_ADD:  w_alu = w_sum[15:0];
            OP_SUB:  w_alu = w_b - Rd1_IDEX;
            OP_XOR:  w_alu = Rd1_IDEX ^ w_b;
            OP_ANDN: w_alu = Rd1_IDEX & ~w_b;
            OP_ROL:  w_alu = (Rd1_IDEX << w_sh) | (Rd1_IDEX >> w_sh_inv);
            OP_SLL:  w_alu = Rd1_IDEX << w_sh;
            OP_ROR:  w_alu = (Rd1_IDEX >> w_sh) | (Rd1_IDEX << w_sh_inv);
            OP_SRL:  w_alu = Rd1_IDEX >> w_sh;
            OP_SEQ:  w_alu = {15'h0000, Rd1_IDEX == w_b};
            OP_SLT:  w_alu = {15'h0000, $signed(Rd1_IDEX) < $signed(w_b)};
            OP_SLE:  w_alu = {15'h0000, $signed(Rd1_IDEX) <= $signed(w_b)};
            OP_SCO:  w_alu = {15'h0000, w_sum[16]};
            OP_BTR:  w_alu = bit_rev16(Rd1_IDEX);
            OP_LBI:  w_alu = w_b;
            OP_SLBI: w_alu = {Rd1_IDEX[7:0], w_b[7:0]};
            OP_MUL:  w_alu = w_mul_res;
        endcase
    end

    always_comb begin
        w_cond   = 1'b0;
        w_target = PCinc_IDEX + Imm_IDEX;
        case (BrType_IDEX)
            BR_BEQZ:   w_cond = (Rd1_IDEX == 16'h0000);
            BR_BNEZ:   w_cond = (Rd1_IDEX != 16'h0000);
            BR_BLTZ:   w_cond = Rd1_IDEX[15];
            BR_BGEZ:   w_cond = ~Rd1_IDEX[15];
            BR_JUMP: begin
                w_cond   = 1'b1;
                w_target = Rd1_IDEX + Imm_IDEX;
            end
            BR_JUMPPC: w_cond = 1'b1;
            default:   w_cond = 1'b0;
        endcase
    end

    assign w_is_jump    = (BrType_IDEX == BR_JUMP) |
                          (BrType_IDEX == BR_JUMPPC);
    assign w_live       = Valid_IDEX & ~exStall;
    assign takeBranch   = w_live & w_cond;
    assign branchTarget = takeBranch ? w_target : 16'h0000;

    // link jumps write the return address instead of the ALU result
    assign w_aluo_d = ~w_live ? 16'h0000 :
                      (w_is_jump & RegWrite_IDEX) ? PCinc_IDEX : w_alu;
    assign w_rd2_d  = w_live ? Rd2_IDEX : 16'h0000;
    assign w_wrr_d  = w_live ? WrR_IDEX : 3'b000;
    assign w_ctl_d  = {7{w_live}} & {w_cond, MemRead_IDEX, MemWrite_IDEX,
                                     MemtoReg_IDEX, RegWrite_IDEX,
                                     Dump_IDEX, halt_IDEX};

    reg16bit u_aluo (
        .clk (clk),
        .rst (rst),
        .en  (freeze),
        .d   (w_aluo_d),
        .q   (ALUO_EXMEM)
    );

    reg16bit u_rd2 (
        .clk (clk),
        .rst (rst),
        .en  (freeze),
        .d   (w_rd2_d),
        .q   (Rd2_EXMEM)
    );

    reg3bit u_wrr (
        .clk (clk),
        .rst (rst),
        .en  (freeze),
        .d   (w_wrr_d),
        .q   (WrR_EXMEM)
    );

    for (genvar gi = 0; gi < 7; gi++) begin : g_ctl
        dff_en u_ff (
            .clk (clk),
            .rst (rst),
            .en  (freeze),
            .d   (w_ctl_d[gi]),
            .q   (w_ctl_q[gi])
        );
    end

    assign {takeBranch_EXMEM, MemRead_EXMEM, MemWrite_EXMEM, MemtoReg_EXMEM,
            RegWrite_EXMEM, Dump_EXMEM, halt_EXMEM} = w_ctl_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: randomized and directed scoreboard bench for execute_stage.
// Multiplier scenarios are exercised when MULT_EN is defined.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        Valid_IDEX;
    logic [15:0] Rd1_IDEX, Rd2_IDEX, Imm_IDEX, PCinc_IDEX;
    logic [3:0]  ALUOp_IDEX;
    logic        ALUSrc_IDEX;
    logic [2:0]  BrType_IDEX;
    logic        MemRead_IDEX, MemWrite_IDEX, MemtoReg_IDEX;
    logic        RegWrite_IDEX, Dump_IDEX, halt_IDEX;
    logic [2:0]  WrR_IDEX;
    logic        takeBranch;
    logic [15:0] branchTarget;
    logic        exStall;
    logic [15:0] ALUO_EXMEM, Rd2_EXMEM;
    logic        takeBranch_EXMEM, MemRead_EXMEM, MemWrite_EXMEM;
    logic        MemtoReg_EXMEM, RegWrite_EXMEM, Dump_EXMEM, halt_EXMEM;
    logic [2:0]  WrR_EXMEM;

    typedef struct packed {
        logic        valid;
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] imm;
        logic [15:0] pcinc;
        logic [3:0]  op;
        logic        src;
        logic [2:0]  br;
        logic        mr, mw, mtr, rw, dump, halt;
        logic [2:0]  wrr;
    } instr_t;

    typedef struct packed {
        logic [15:0] aluo;
        logic [15:0] rd2;
        logic        tb, mr, mw, mtr, rw, dump, halt;
        logic [2:0]  wrr;
    } exp_t;

    exp_t sbq[$];
    exp_t exp_reg;
    int   vectors = 0;
    int   miscompares = 0;

    execute_stage dut (
        .clk              (clk),
        .rst              (rst),
        .freeze           (freeze),
        .Valid_IDEX       (Valid_IDEX),
        .Rd1_IDEX         (Rd1_IDEX),
        .Rd2_IDEX         (Rd2_IDEX),
        .Imm_IDEX         (Imm_IDEX),
        .PCinc_IDEX       (PCinc_IDEX),
        .ALUOp_IDEX       (ALUOp_IDEX),
        .ALUSrc_IDEX      (ALUSrc_IDEX),
        .BrType_IDEX      (BrType_IDEX),
        .MemRead_IDEX     (MemRead_IDEX),
        .MemWrite_IDEX    (MemWrite_IDEX),
        .MemtoReg_IDEX    (MemtoReg_IDEX),
        .RegWrite_IDEX    (RegWrite_IDEX),
        .Dump_IDEX        (Dump_IDEX),
        .halt_IDEX        (halt_IDEX),
        .WrR_IDEX         (WrR_IDEX),
        .takeBranch       (takeBranch),
        .branchTarget     (branchTarget),
        .exStall          (exStall),
        .ALUO_EXMEM       (ALUO_EXMEM),
        .Rd2_EXMEM        (Rd2_EXMEM),
        .takeBranch_EXMEM (takeBranch_EXMEM),
        .MemRead_EXMEM    (MemRead_EXMEM),
        .MemWrite_EXMEM   (MemWrite_EXMEM),
        .MemtoReg_EXMEM   (MemtoReg_EXMEM),
        .RegWrite_EXMEM   (RegWrite_EXMEM),
        .Dump_EXMEM       (Dump_EXMEM),
        .halt_EXMEM       (halt_EXMEM),
        .WrR_EXMEM        (WrR_EXMEM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp);
        end
    endtask

    function automatic logic [63:0] exmem_now();
        return {22'h0, ALUO_EXMEM, Rd2_EXMEM, takeBranch_EXMEM, MemRead_EXMEM,
                MemWrite_EXMEM, MemtoReg_EXMEM, RegWrite_EXMEM, Dump_EXMEM,
                halt_EXMEM, WrR_EXMEM};
    endfunction

    // reference ALU written from the operation table, one bit at a time
    function automatic logic [15:0] ref_alu(input logic [3:0] op,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
        int s, sa, sb;
        logic [15:0] r;
        s  = int'(b[3:0]);
        sa = a[15] ? int'(a) - 65536 : int'(a);
        sb = b[15] ? int'(b) - 65536 : int'(b);
        r  = 16'h0000;
        case (op)
            4'd0:  r = 16'((int'(a) + int'(b)) % 65536);
            4'd1:  r = 16'((int'(b) - int'(a) + 65536) % 65536);
            4'd2:  r = a ^ b;
            4'd3:  r = a & ~b;
            4'd4: begin r = a; repeat (s) r = {r[14:0], r[15]}; end
            4'd5: begin r = a; repeat (s) r = {r[14:0], 1'b0}; end
            4'd6: begin r = a; repeat (s) r = {r[0], r[15:1]}; end
            4'd7: begin r = a; repeat (s) r = {1'b0, r[15:1]}; end
            4'd8:  r = (a == b) ? 16'd1 : 16'd0;
            4'd9:  r = (sa < sb) ? 16'd1 : 16'd0;
            4'd10: r = (sa <= sb) ? 16'd1 : 16'd0;
            4'd11: r = (int'(a) + int'(b) > 65535) ? 16'd1 : 16'd0;
            4'd12: for (int i = 0; i < 16; i++) r[i] = a[15-i];
            4'd13: r = b;
            4'd14: r = {a[7:0], b[7:0]};
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    task automatic ref_br(input instr_t i, input logic stall,
                          output logic tk, output logic [15:0] tg);
        logic c;
        logic [15:0] t;
        c = 1'b0;
        t = i.pcinc + i.imm;
        case (i.br)
            3'd1: c = (i.rd1 == 16'h0000);
            3'd2: c = (i.rd1 != 16'h0000);
            3'd3: c = i.rd1[15];
            3'd4: c = !i.rd1[15];
            3'd5: begin c = 1'b1; t = i.rd1 + i.imm; end
            3'd6: c = 1'b1;
            default: c = 1'b0;
        endcase
        tk = i.valid & c & !stall;
        tg = tk ? t : 16'h0000;
    endtask

    task automatic ref_exmem(input instr_t i, input logic stall,
                             input logic [15:0] res, output exp_t e);
        logic tk;
        logic [15:0] tg;
        e = '0;
        if (i.valid && !stall) begin
            ref_br(i, stall, tk, tg);
            e.aluo = ((i.br == 3'd5 || i.br == 3'd6) && i.rw) ? i.pcinc : res;
            e.rd2  = i.rd2;
            e.tb   = tk;
            e.mr   = i.mr;
            e.mw   = i.mw;
            e.mtr  = i.mtr;
            e.rw   = i.rw;
            e.dump = i.dump;
            e.halt = i.halt;
            e.wrr  = i.wrr;
        end
    endtask

    task automatic drive(input instr_t i);
        Valid_IDEX    = i.valid;
        Rd1_IDEX      = i.rd1;
        Rd2_IDEX      = i.rd2;
        Imm_IDEX      = i.imm;
        PCinc_IDEX    = i.pcinc;
        ALUOp_IDEX    = i.op;
        ALUSrc_IDEX   = i.src;
        BrType_IDEX   = i.br;
        MemRead_IDEX  = i.mr;
        MemWrite_IDEX = i.mw;
        MemtoReg_IDEX = i.mtr;
        RegWrite_IDEX = i.rw;
        Dump_IDEX     = i.dump;
        halt_IDEX     = i.halt;
        WrR_IDEX      = i.wrr;
    endtask

    // one cycle: drive at negedge, check redirect/stall, queue the EX/MEM value
    task automatic step(input instr_t i, input logic frz, input logic stall,
                        input logic [15:0] res);
        logic tk;
        logic [15:0] tg;
        exp_t e;
        drive(i);
        freeze = frz;
        #1;
        ref_br(i, stall, tk, tg);
        chk("redirect/stall", {46'h0, takeBranch, branchTarget, exStall},
            {46'h0, tk, tg, stall});
        if (frz) begin
            ref_exmem(i, stall, res, e);
            exp_reg = e;
        end
        sbq.push_back(exp_reg);
        @(negedge clk);
    endtask

    task automatic issue(input instr_t i, input logic frz);
        step(i, frz, 1'b0, ref_alu(i.op, i.rd1, i.src ? i.imm : i.rd2));
    endtask

    function automatic instr_t mk(input logic [3:0] op, input logic [15:0] a,
                                  input logic [15:0] b);
        instr_t i;
        i = '0;
        i.valid = 1'b1;
        i.op    = op;
        i.rd1   = a;
        i.rd2   = b;
        i.rw    = 1'b1;
        i.wrr   = 3'd3;
        i.pcinc = 16'h0040;
        return i;
    endfunction

`ifdef MULT_EN
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                           input int hold);
        instr_t i;
        logic [15:0] p;
        i = mk(4'd15, a, b);
        i.wrr = 3'd5;
        p = 16'(longint'(a) * longint'(b));
        for (int k = 0; k < 17; k++) step(i, 1'b1, 1'b1, p);
        for (int k = 0; k < hold; k++) step(i, 1'b0, 1'b0, p);
        step(i, 1'b1, 1'b0, p);
    endtask
`endif

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("exmem", exmem_now(), {22'h0, e});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        instr_t i;
        int maxop;
        exp_reg = '0;
        rst = 1'b1;
        freeze = 1'b0;
        drive('0);
        repeat (3) @(negedge clk);
        chk("reset exmem", exmem_now(), 64'h0);
        chk("reset comb", {46'h0, takeBranch, branchTarget, exStall}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        issue(mk(4'd0, 16'h7FFF, 16'h0001), 1'b1);
        issue(mk(4'd9, 16'hFFFF, 16'h0001), 1'b1);
        issue(mk(4'd11, 16'hFFFF, 16'h0001), 1'b1);
        i = mk(4'd0, 16'h8000, 16'h0003);
        i.br = 3'd3; i.pcinc = 16'h0010; i.imm = 16'hFFF8;
        issue(i, 1'b1);
        i = mk(4'd2, 16'h1234, 16'h00FF);
        i.valid = 1'b0; i.mw = 1'b1;
        issue(i, 1'b1);
        i = mk(4'd13, 16'h0000, 16'h0000);
        i.br = 3'd5; i.imm = 16'h0100; i.rd1 = 16'h0020;
        issue(i, 1'b1);
        issue(mk(4'd4, 16'h8001, 16'h0000), 1'b1);
        issue(mk(4'd6, 16'h0001, 16'h000F), 1'b0);
        issue(mk(4'd10, 16'h8000, 16'h8000), 1'b1);

`ifdef MULT_EN
        run_mul(16'h0003, 16'h0005, 0);
        run_mul(16'h0003, 16'h0005, 3);
        issue(mk(4'd0, 16'h1111, 16'h2222), 1'b1);
        i = mk(4'd15, 16'h1234, 16'h0057);
        for (int k = 0; k < 9; k++) step(i, 1'b0, 1'b1, 16'h0000);
        rst = 1'b1;
        i.valid = 1'b0;
        drive(i);
        #1;
        chk("reset mid-mul exmem", exmem_now(), 64'h0);
        chk("reset mid-mul stall", {63'h0, exStall}, 64'h0);
        exp_reg = '0;
        sbq.push_back(exp_reg);
        @(negedge clk);
        rst = 1'b0;
        run_mul(16'h0100, 16'h0100, 0);
        maxop = 14;
`else
        issue(mk(4'd15, 16'h0003, 16'h0005), 1'b1);
        maxop = 15;
`endif

        for (int n = 0; n < 400; n++) begin
            i = '0;
            i.valid = ($urandom_range(0, 99) < 85);
            i.rd1   = 16'($urandom);
            i.rd2   = 16'($urandom);
            i.imm   = 16'($urandom);
            i.pcinc = 16'($urandom);
            i.op    = 4'($urandom_range(0, maxop));
            i.src   = 1'($urandom);
            i.br    = 3'($urandom);
            i.mr    = 1'($urandom);
            i.mw    = 1'($urandom);
            i.mtr   = 1'($urandom);
            i.rw    = 1'($urandom);
            i.dump  = 1'($urandom);
            i.halt  = 1'($urandom);
            i.wrr   = 3'($urandom);
            if (n % 16 == 0) i.rd1 = 16'h0000;
            issue(i, ($urandom_range(0, 99) < 80));
        end

        drive('0);
        freeze = 1'b0;
        repeat (2) @(negedge clk);
        chk("scoreboard drained", 64'(sbq.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 16-bit five-stage pipeline, sitting between the ID/EX latch and the memory stage. Computes the ALU result, resolves branches and jumps, and owns the EX/MEM pipeline register that the memory stage consumes. Optionally contains a 16-cycle iterative multiplier that stalls the front of the pipe while it runs.

## Interface
- No parameters; data width is fixed at 16 bits.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- freeze  in  1  EX/MEM load enable: 1 = latch this cycle, 0 = hold (same sense as the memory stage)
- Valid_IDEX  in  1  instruction in EX is real; 0 = bubble
- Rd1_IDEX, Rd2_IDEX  in  16  register operands A and B
- Imm_IDEX  in  16  sign/zero-extended immediate
- PCinc_IDEX  in  16  PC+2 of this instruction
- ALUOp_IDEX  in  4  operation code (see Operation)
- ALUSrc_IDEX  in  1  1 = B operand is Imm_IDEX
- BrType_IDEX  in  3  0 none, 1 BEQZ, 2 BNEZ, 3 BLTZ, 4 BGEZ, 5 JUMP (target Rd1+Imm), 6 JUMPPC (target PCinc+Imm)
- MemRead_IDEX, MemWrite_IDEX, MemtoReg_IDEX, RegWrite_IDEX, Dump_IDEX, halt_IDEX  in  1 each  control passthrough
- WrR_IDEX  in  3  destination register
- takeBranch  out  1  combinational redirect request this cycle
- branchTarget  out  16  combinational redirect address
- exStall  out  1  EX busy; upstream must hold ID/EX and not advance
- ALUO_EXMEM, Rd2_EXMEM  out  16  registered result and store data
- takeBranch_EXMEM, MemRead_EXMEM, MemWrite_EXMEM, MemtoReg_EXMEM, RegWrite_EXMEM, Dump_EXMEM, halt_EXMEM  out  1 each  registered
- WrR_EXMEM  out  3  registered destination

## Operation
- B = ALUSrc ? Imm : Rd2. Ops: 0 ADD A+B, 1 SUB B−A, 2 XOR, 3 ANDN A&~B, 4 ROL, 5 SLL, 6 ROR, 7 SRL (shift amount B[3:0]), 8 SEQ, 9 SLT, 10 SLE (signed, result 16'h0001/16'h0000), 11 SCO (carry out of A+B), 12 BTR (bit-reverse A), 13 LBI (B), 14 SLBI ({A[7:0],B[7:0]}), 15 MUL.
- All arithmetic modulo 2^16; SLT/SLE use true signed compare (no overflow error).
- Branch conditions test Rd1 only: BEQZ Rd1==0, BNEZ Rd1!=0, BLTZ Rd1[15], BGEZ !Rd1[15]; conditional target PCinc+Imm.
- takeBranch = Valid & condition & !exStall. branchTarget valid only when takeBranch=1; otherwise 0.
- JUMP/JUMPPC with RegWrite (link) write PCinc as ALUO.
- Valid=0: all registered control bits load as 0; data fields don't-care (load 0).
- MUL FSM (sub-module): IDLE → BUSY on Valid & op15 & IDLE; BUSY counts 16 shift-add iterations; → DONE; DONE → IDLE when freeze=1 (result latched). Low 16 bits of product kept.
- exStall = (Valid & op15 & state≠DONE). Non-MUL ops never stall.
- Reset mid-multiply: FSM to IDLE, counter 0, accumulated product discarded.

## Timing
- ALU and branch: zero-latency combinational to EX/MEM D inputs; visible on EX/MEM outputs the cycle after freeze=1.
- MUL: issued cycle N; exStall high cycles N..N+16; DONE in N+17, exStall low, result latched at end of N+17 if freeze=1; if freeze=0, DONE holds result until freeze=1.
- EX/MEM register holds during freeze=0 regardless of exStall.
- While exStall=1 with freeze=1, EX/MEM loads a bubble (all control 0).
- Reset: every EX/MEM output 0; FSM IDLE; takeBranch/exStall 0 after reset since combinational on reset-cleared state and inputs.

## Configuration
- MULT_EN defined: op 15 runs the iterative multiplier as above.
- MULT_EN undefined: multiplier and FSM absent; op 15 completes in one cycle with ALUO = 16'h0000; exStall tied 0.

## Structure
- Shared package exec_pkg: ALU opcode constants (4-bit), branch-type constants (3-bit), MULT_ITERS = 16.
- One sub-module: seq_mult (clk, rst, start, a, b, busy, done, ack, product[15:0]), instantiated only under MULT_EN.
- EX/MEM register built from existing reg16bit/reg3bit/dff_en cells.

## Test plan
- ADD Rd1=16'h7FFF, Rd2=16'h0001, freeze=1 -> ALUO_EXMEM=16'h8000 next cycle, RegWrite_EXMEM=1.
- SLT Rd1=16'hFFFF (−1), Rd2=16'h0001 -> ALUO_EXMEM=16'h0001; SCO with 16'hFFFF+16'h0001 -> 16'h0001.
- BLTZ Rd1=16'h8000, PCinc=16'h0010, Imm=16'hFFF8 -> takeBranch=1, branchTarget=16'h0008, takeBranch_EXMEM=1 next cycle.
- Valid=0 with MemWrite_IDEX=1 -> MemWrite_EXMEM=0, RegWrite_EXMEM=0.
- MULT_EN: MUL 16'h0003×16'h0005 -> exStall high 17 cycles, then ALUO_EXMEM=16'h000F; repeat with freeze=0 during DONE for 3 cycles -> result held, latched when freeze=1.
- Assert rst at BUSY iteration 8 -> all EX/MEM outputs 0 immediately, exStall drops, next MUL 16'h0100×16'h0100 -> 16'h0000.
